// File: rtl/psum_writeback.sv
// psum_writeback: drains output vectors from the corelet OFIFO and writes them
// to a contiguous range of psum SRAM, either overwriting or accumulating with
// the partial sum already stored there. A single start pulse runs a whole job.
//
// Build option: define PSUM_WRITEBACK_RELU_EN to clamp every negative lane of
// the written value to zero. Without it the sum is written unchanged.
//
// All outputs are registered, so the SRAM and OFIFO act on a command in the
// cycle after the state that decided it. A read issued from POP is therefore
// presented to the SRAM during RD_WAIT and its data returns during WRITE; the
// per-lane accumulate is formed in WRITE, straight into the write-data register.
module psum_writeback #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     num_vec,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic                   acc_en,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] ofifo_data,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_addr,
  output logic [psum_bw*col-1:0] sram_din,
  input  logic [psum_bw*col-1:0] sram_dout,
  output logic                   busy,
  output logic                   done
);

  localparam int VW = psum_bw * col;
  localparam logic [addr_bw-1:0] ADDR_ZERO = {addr_bw{1'b0}};
  localparam logic [addr_bw-1:0] ADDR_ONE  = {{(addr_bw-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [addr_bw-1:0] num_q, num_d;
  logic [addr_bw-1:0] cur_addr_q, cur_addr_d;
  logic [addr_bw-1:0] cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic [VW-1:0]      data_q, data_d;

  logic               ofifo_rd_q, ofifo_rd_d;
  logic               cen_q, cen_d;
  logic               wen_q, wen_d;
  logic [addr_bw-1:0] addr_q, addr_d;
  logic [VW-1:0]      din_q, din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [VW-1:0]      wr_sum_s;
  logic [VW-1:0]      wr_val_s;

  // Independent per-lane add; each lane wraps at psum_bw bits with no carry
  // into its neighbour (two's-complement add is sign-agnostic).
  function automatic logic [VW-1:0] lane_add(input logic [VW-1:0] a,
                                             input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = {VW{1'b0}};
    for (int i = 0; i < col; i++) begin
      r[i*psum_bw +: psum_bw] = a[i*psum_bw +: psum_bw] + b[i*psum_bw +: psum_bw];
    end
    return r;
  endfunction

`ifdef PSUM_WRITEBACK_RELU_EN
  // Zero every lane whose sign bit is set.
  function automatic logic [VW-1:0] lane_relu(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < col; i++) begin
      if (v[i*psum_bw + psum_bw - 1]) begin
        r[i*psum_bw +: psum_bw] = {psum_bw{1'b0}};
      end else begin
        r[i*psum_bw +: psum_bw] = v[i*psum_bw +: psum_bw];
      end
    end
    return r;
  endfunction
`endif

  // Value to be written: fresh OFIFO data, or that data plus the stored psum.
  always_comb begin
    if (acc_q) begin
      wr_sum_s = lane_add(data_q, sram_dout);
    end else begin
      wr_sum_s = data_q;
    end
  end

`ifdef PSUM_WRITEBACK_RELU_EN
  assign wr_val_s = lane_relu(wr_sum_s);
`else
  assign wr_val_s = wr_sum_s;
`endif

  // Next-state and next-output decode for the drain sequencer.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    data_d     = data_q;
    ofifo_rd_d = 1'b0;
    cen_d      = 1'b1;
    wen_d      = 1'b1;
    addr_d     = addr_q;
    din_d      = din_q;
    done_d     = 1'b0;
    busy_d     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d      = num_vec;
          acc_d      = acc_en;
          cur_addr_d = base_addr;
          cnt_d      = ADDR_ZERO;
          if (num_vec == ADDR_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_POP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_POP: begin
        if (ofifo_valid) begin
          data_d     = ofifo_data;
          ofifo_rd_d = 1'b1;
          if (acc_q) begin
            cen_d   = 1'b0;
            wen_d   = 1'b1;
            addr_d  = cur_addr_q;
            state_d = S_RD_WAIT;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_POP;
        end
      end

      S_RD_WAIT: begin
        state_d = S_WRITE;
      end

      S_WRITE: begin
        cen_d      = 1'b0;
        wen_d      = 1'b0;
        addr_d     = cur_addr_q;
        din_d      = wr_val_s;
        cur_addr_d = cur_addr_q + ADDR_ONE;
        cnt_d      = cnt_q + ADDR_ONE;
        if (cnt_q == (num_q - ADDR_ONE)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_POP;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, job context and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      num_q      <= ADDR_ZERO;
      cur_addr_q <= ADDR_ZERO;
      cnt_q      <= ADDR_ZERO;
      acc_q      <= 1'b0;
      data_q     <= {VW{1'b0}};
      ofifo_rd_q <= 1'b0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      addr_q     <= ADDR_ZERO;
      din_q      <= {VW{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      ofifo_rd_q <= ofifo_rd_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ofifo_rd  = ofifo_rd_q;
  assign sram_cen  = cen_q;
  assign sram_wen  = wen_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
